// File: rtl/shift_in_loader.sv
`default_nettype none
// ============================================================================
// Module   : shift_in_loader
// Purpose  : Serial-to-parallel frame receiver (MSB first, even parity) that
//            produces a data/enable load strobe for a downstream register.
// Revision : 1.0 - initial release
// ============================================================================

module shift_in_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_sin,
  input  logic             io_sin_valid,
  input  logic             io_sin_start,
  output logic [WIDTH-1:0] io_D,
  output logic             io_enable,
  output logic             io_busy,
  output logic             io_frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_d;
  logic             r_enable;
  logic             r_err;

  logic w_start;
  logic w_data;
  logic w_parity_ok;
  logic w_load_first;
  logic w_shift_en;
  logic w_commit;
  logic w_err;

  assign w_start     = io_sin_valid & io_sin_start;
  assign w_data      = io_sin_valid & ~io_sin_start;
  assign w_parity_ok = ~((^r_shift) ^ io_sin);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_start) begin
          w_next = S_SHIFT;
        end else if (w_data && (r_count == CW'(WIDTH - 1))) begin
          w_next = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_start) begin
          w_next = S_SHIFT;
        end else if (w_data) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output / datapath control; a start bit always opens a fresh frame,
  // and aborts whatever frame was in progress.
  always_comb begin
    w_load_first = w_start;
    w_shift_en   = (r_state == S_SHIFT) & w_data;
    w_commit     = (r_state == S_PARITY) & w_data & w_parity_ok;
    w_err        = ((r_state != S_IDLE) & w_start) |
                   ((r_state == S_PARITY) & w_data & ~w_parity_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_shift  <= '0;
      r_d      <= '0;
      r_enable <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_enable <= w_commit;
      r_err    <= w_err;
      if (w_load_first) begin
        r_shift <= {{(WIDTH-1){1'b0}}, io_sin};
        r_count <= CW'(1);
      end else if (w_shift_en) begin
        r_shift <= {r_shift[WIDTH-2:0], io_sin};
        r_count <= r_count + CW'(1);
      end
      if (w_commit) begin
        r_d <= r_shift;
      end
    end
  end

  assign io_D         = r_d;
  assign io_enable    = r_enable;
  assign io_frame_err = r_err;
  assign io_busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shift_in_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_in_loader
// Purpose  : Directed self-checking bench for shift_in_loader (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================

module tb_shift_in_loader;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             io_sin;
  logic             io_sin_valid;
  logic             io_sin_start;
  logic [WIDTH-1:0] io_D;
  logic             io_enable;
  logic             io_busy;
  logic             io_frame_err;

  int checks;
  int errors;
  int n_en;
  int n_err;
  int cyc;
  int en_base;
  int err_base;
  int t_first;
  int t_second;

  shift_in_loader #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_sin       (io_sin),
    .io_sin_valid (io_sin_valid),
    .io_sin_start (io_sin_start),
    .io_D         (io_D),
    .io_enable    (io_enable),
    .io_busy      (io_busy),
    .io_frame_err (io_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters sample the value held during the cycle just ending.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (io_enable)    n_en  <= n_en + 1;
    if (io_frame_err) n_err <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives inputs and returns at the next negedge.
  task automatic step(input logic v, input logic b, input logic s);
    io_sin_valid = v;
    io_sin       = b;
    io_sin_start = s;
    @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] w, input int gaps);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, w[i], (i == 7));
      for (int g = 0; g < ((gaps != 0) ? (i % 6) : 0); g++) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; n_en = 0; n_err = 0; cyc = 0;
    reset = 1'b1; io_sin = 1'b0; io_sin_valid = 1'b0; io_sin_start = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Reset state
    chk("rst_D",      32'(io_D),         32'h00);
    chk("rst_enable", 32'(io_enable),    32'h0);
    chk("rst_err",    32'(io_frame_err), 32'h0);
    chk("rst_busy",   32'(io_busy),      32'h0);
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    chk("idle_nostart_busy", 32'(io_busy), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    chk("idle_nostart_err", 32'(io_frame_err), 32'h0);

    // Parity error on 0xA5
    send_data(8'hA5, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("perr_err",    32'(io_frame_err), 32'h1);
    chk("perr_enable", 32'(io_enable),    32'h0);
    chk("perr_D",      32'(io_D),         32'h00);
    step(1'b0, 1'b0, 1'b0);
    chk("perr_err_1cyc", 32'(io_frame_err), 32'h0);

    // Good frame 0xA5
    step(1'b1, 1'b1, 1'b1);
    chk("good_busy_after_start", 32'(io_busy), 32'h1);
    for (int i = 6; i >= 0; i--) step(1'b1, ((8'hA5 >> i) & 8'h01) != 0, 1'b0);
    chk("good_busy_in_parity", 32'(io_busy), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    chk("good_enable", 32'(io_enable), 32'h1);
    chk("good_D",      32'(io_D),      32'hA5);
    chk("good_busy",   32'(io_busy),   32'h0);
    step(1'b0, 1'b0, 1'b0);
    chk("good_enable_1cyc", 32'(io_enable), 32'h0);
    chk("good_D_hold",      32'(io_D),      32'hA5);

    // Gapped frame 0x3C
    step(1'b0, 1'b0, 1'b0);
    en_base = n_en;
    send_data(8'h3C, 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_busy_held", 32'(io_busy), 32'h1);
    step(1'b1, 1'b0, 1'b0);
    chk("gap_enable", 32'(io_enable), 32'h1);
    chk("gap_D",      32'(io_D),      32'h3C);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_en_pulses", 32'(n_en - en_base), 32'd1);

    // Restart: 4 bits then a start-marked 0xFF
    en_base = n_en; err_base = n_err;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("restart_err", 32'(io_frame_err), 32'h1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("restart_enable", 32'(io_enable), 32'h1);
    chk("restart_D",      32'(io_D),      32'hFF);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("restart_err_pulses", 32'(n_err - err_base), 32'd1);
    chk("restart_en_pulses",  32'(n_en - en_base),   32'd1);

    // Reset mid-frame, stray bits, then 0x81
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    chk("midrst_busy", 32'(io_busy), 32'h0);
    chk("midrst_D",    32'(io_D),    32'h00);
    en_base = n_en; err_base = n_err;
    for (int i = 0; i < 6; i++) step(1'b1, 1'(i & 1), 1'b0);
    chk("midrst_stray_busy", 32'(io_busy), 32'h0);
    send_data(8'h81, 0);
    step(1'b1, 1'b0, 1'b0);
    chk("midrst_enable", 32'(io_enable), 32'h1);
    chk("midrst_D81",    32'(io_D),      32'h81);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("midrst_err_pulses", 32'(n_err - err_base), 32'd0);
    chk("midrst_en_pulses",  32'(n_en - en_base),   32'd1);

    // Back-to-back 0x12 (parity 0) then 0x34 (parity 1)
    err_base = n_err;
    send_data(8'h12, 0);
    step(1'b1, 1'b0, 1'b0);
    chk("b2b_enable1", 32'(io_enable), 32'h1);
    chk("b2b_D1",      32'(io_D),      32'h12);
    t_first = cyc;
    send_data(8'h34, 0);
    step(1'b1, 1'b1, 1'b0);
    chk("b2b_enable2", 32'(io_enable), 32'h1);
    chk("b2b_D2",      32'(io_D),      32'h34);
    t_second = cyc;
    chk("b2b_spacing", 32'(t_second - t_first), 32'd9);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_err_pulses", 32'(n_err - err_base), 32'd0);

    // Start marker in the parity slot aborts the frame
    send_data(8'h55, 0);
    step(1'b1, 1'b1, 1'b1);
    chk("abort_par_err",    32'(io_frame_err), 32'h1);
    chk("abort_par_enable", 32'(io_enable),    32'h0);
    chk("abort_par_busy",   32'(io_busy),      32'h1);
    chk("abort_par_D",      32'(io_D),         32'h34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_in_loader.md
SHIFT_IN_LOADER -- requirements
Module: shift_in_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port io_sin, input, 1, serial data bit, MSB first.
REQ-005 The block SHALL have port io_sin_valid, input, 1, qualifies io_sin; a bit is accepted only on a cycle with io_sin_valid=1.
REQ-006 The block SHALL have port io_sin_start, input, 1, frame marker, meaningful only with io_sin_valid=1; marks the accepted bit as the first data bit (MSB) of a frame.
REQ-007 The block SHALL have port io_D, output, WIDTH, last correctly received word, in the data/enable format consumed by NRegisterE.
REQ-008 The block SHALL have port io_enable, output, 1, one-cycle load strobe qualifying io_D.
REQ-009 The block SHALL have port io_busy, output, 1, high while a frame is in progress (state SHIFT or PARITY).
REQ-010 The block SHALL have port io_frame_err, output, 1, one-cycle error strobe.

Function
REQ-011 The frame SHALL be WIDTH data bits, MSB first, followed by one even-parity bit, so the XOR of the data bits and the parity bit is 0.
REQ-012 The FSM SHALL have states IDLE, SHIFT and PARITY, with a bit counter of ceil(log2(WIDTH+1)) bits and a WIDTH-bit shift register.
REQ-013 In IDLE, an accepted bit with io_sin_start=1 SHALL load the bit into the shift-register LSB, set count=1 and go to SHIFT.
REQ-014 In IDLE, an accepted bit with io_sin_start=0 SHALL be ignored, with no state change and no error.
REQ-015 In SHIFT, each accepted bit with io_sin_start=0 SHALL shift left into the LSB and increment count; when count reaches WIDTH, the FSM SHALL go to PARITY.
REQ-016 Cycles with io_sin_valid=0 SHALL hold all state; gaps of any length SHALL be tolerated.
REQ-017 In PARITY, an accepted bit SHALL be checked against the shift register and the FSM SHALL return to IDLE.
REQ-018 On a parity pass, io_D SHALL be updated to the shift-register value and io_enable SHALL be 1 for exactly one cycle, the cycle after the parity bit is accepted (latency 1).
REQ-019 On a parity fail, io_frame_err SHALL be 1 for one cycle, the cycle after the parity bit is accepted; io_D SHALL be unchanged and io_enable SHALL stay 0.
REQ-020 An accepted bit with io_sin_start=1 in SHIFT or PARITY SHALL abort the current frame.
  - io_frame_err pulses the next cycle.
  - The new bit starts a fresh frame: count=1, state SHIFT.
REQ-021 Back-to-back frames SHALL be supported: an io_sin_start bit accepted in the same cycle io_enable is high SHALL start a new frame with no lost bit.
REQ-022 io_D SHALL hold its value between strobes; io_enable and io_frame_err SHALL never be high in the same cycle.
REQ-023 io_busy SHALL be combinational from state: 1 in SHIFT or PARITY, 0 in IDLE.

Reset
REQ-024 While reset=1 at a clock edge, the FSM SHALL go to IDLE, count and the shift register SHALL clear, io_D SHALL be 0, and io_enable, io_frame_err and io_busy SHALL be 0.
REQ-025 Reset SHALL take priority over every input, including mid-frame, and a partial frame SHALL be discarded with no strobe.
REQ-026 Reset SHALL NOT change outputs asynchronously.

Verification
REQ-027 Good frame: WIDTH=8, bits 1,0,1,0,0,1,0,1 (start on the first), parity 0 -> io_enable=1 for one cycle, io_D=0xA5, io_busy high from the cycle after the start bit until the cycle after parity.
REQ-028 Parity error: the 0xA5 frame with parity 1 -> io_frame_err pulse, io_enable=0, io_D keeps its prior value (0x00 after reset).
REQ-029 Gaps: 0x3C with 0-5 idle cycles of io_sin_valid=0 inserted between bits, parity 0 -> io_D=0x3C, one io_enable pulse, timing relative to the parity bit unchanged.
REQ-030 Restart: 4 bits of a frame, then a start-marked frame 0xFF with parity 0 -> one io_frame_err pulse after the restart bit, then io_enable with io_D=0xFF.
REQ-031 Reset mid-frame: assert reset for 1 cycle after 5 bits, then send 6 bits without start, then a full 0x81 frame with parity 0 -> no strobes until io_enable with io_D=0x81.
REQ-032 Back-to-back: 0x12 (parity 0) immediately followed by 0x34 (parity 1) with no idle cycle -> two io_enable pulses 9 cycles apart, io_D=0x12 then 0x34.
